// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and framing constants.
// The transmitter reuses the data-bit count and default baud divisor.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for a single asynchronous input bit.
// RESET_VALUE lets an idle-high line come out of reset without a false edge.
module uart_sync #(
  parameter int   DEPTH       = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages_reg;
  logic [DEPTH:0]   shifted;

  // One spare bit on top keeps the slice legal even for DEPTH = 1.
  assign shifted = {stages_reg, d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages_reg <= {DEPTH{RESET_VALUE}};
    end else begin
      stages_reg <= shifted[DEPTH-1:0];
    end
  end

  assign q = stages_reg[DEPTH-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: mid-bit sampling of a synchronised rx line,
// one-cycle recv_ok / frame_err strobes, BREAK state for held-low lines.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] recv_data,
  output logic                      recv_ok,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [IDX_W-1:0]          idx_reg, idx_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic                      good_next, bad_next;

  uart_sync #(
    .DEPTH      (2),
    .RESET_VALUE(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    good_next  = 1'b0;
    bad_next   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // Re-check the start bit half a bit in; a high line here was a glitch.
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == IDX_LAST) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            good_next  = 1'b1;
            state_next = IDLE;
          end else begin
            bad_next   = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes come from the STOP decision only, so they can never overlap or repeat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recv_data <= '0;
      recv_ok   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      recv_ok   <= good_next;
      frame_err <= bad_next;
      if (good_next) begin
        recv_data <= shift_reg;
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clocks per bit: expected strobes are
// queued as frames are driven and checked by a monitor as the DUT emits them.
module tb_uart_receiver;

  localparam int CPB    = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;

  typedef struct {
    logic       ok;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] recv_data;
  logic       recv_ok;
  logic       frame_err;
  logic       busy;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] last_data = 8'h00;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .recv_data(recv_data),
    .recv_ok  (recv_ok),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe is matched against the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset && (recv_ok || frame_err)) begin
      n_cmp++;
      if ((recv_ok && frame_err) || prev_strobe) begin
        n_fail++;
        $display("FAIL strobe_shape: cyc=%0d recv_ok=%b frame_err=%b prev=%b, required single isolated strobe",
                 cyc, recv_ok, frame_err, prev_strobe);
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: cyc=%0d recv_ok=%b frame_err=%b data=%h, required no strobe",
                 cyc, recv_ok, frame_err, recv_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (recv_ok !== e.ok || recv_data !== e.data) begin
          n_fail++;
          $display("FAIL strobe_data: cyc=%0d got ok=%b data=%h, required ok=%b data=%h",
                   cyc, recv_ok, recv_data, e.ok, e.data);
        end
        if (e.due >= 0) begin
          n_cmp++;
          if (cyc !== e.due) begin
            n_fail++;
            $display("FAIL strobe_cycle: got cyc=%0d, required cyc=%0d", cyc, e.due);
          end
        end
      end
      $display("strobe cyc=%0d recv_ok=%b frame_err=%b recv_data=%h", cyc, recv_ok, frame_err, recv_data);
    end
    prev_strobe = !reset && (recv_ok || frame_err);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Drives frame bits first..last (0 = start, 1..8 = data LSB first, 9 = stop).
  task automatic drive_bits(input logic [7:0] data, input logic stop, input int bit_ns,
                            input int first, input int last);
    logic [9:0] f;
    f = {stop, data, 1'b0};
    for (int i = first; i <= last; i++) begin
      rx = f[i];
      #(bit_ns);
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_cmp++; if (recv_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, required 00", recv_data); end
    n_cmp++; if (recv_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b, required 0", recv_ok); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b, required 0", busy); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int p;
    @(negedge clk);
    p = cyc;
    exp_q.push_back('{ok: 1'b1, data: 8'h55, due: p + 2 + CPB / 2 + 9 * CPB + 1});
    last_data = 8'h55;
    drive_bits(8'h55, 1'b1, BIT_NS, 0, 4);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_mid: got %b, required 1", busy); end
    drive_bits(8'h55, 1'b1, BIT_NS, 5, 9);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL good_drain: %0d strobes missing, required 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_end: got %b, required 0", busy); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int p;
    @(negedge clk);
    p = cyc;
    exp_q.push_back('{ok: 1'b1, data: 8'h00, due: p + 2 + CPB / 2 + 9 * CPB + 1});
    exp_q.push_back('{ok: 1'b1, data: 8'hFF, due: p + 2 + CPB / 2 + 19 * CPB + 1});
    last_data = 8'hFF;
    drive_bits(8'h00, 1'b1, BIT_NS, 0, 9);
    drive_bits(8'hFF, 1'b1, BIT_NS, 0, 9);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_drain: %0d strobes missing, required 0", exp_q.size()); exp_q.delete(); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b, required 0", busy); end
    @(negedge clk);
    exp_q.push_back('{ok: 1'b1, data: 8'hA5, due: -1});
    last_data = 8'hA5;
    drive_bits(8'hA5, 1'b1, BIT_NS, 0, 9);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL glitch_drain: %0d strobes missing, required 0", exp_q.size()); exp_q.delete(); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame_error();
    @(negedge clk);
    exp_q.push_back('{ok: 1'b0, data: last_data, due: -1});
    drive_bits(8'h3C, 1'b0, BIT_NS, 0, 9);
    #(40 * CLK_NS);
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ferr_drain: %0d strobes missing, required 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b, required 1", busy); end
    n_cmp++; if (recv_data !== last_data) begin n_fail++; $display("FAIL ferr_data_held: got %h, required %h", recv_data, last_data); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_break_exit: got %b, required 0", busy); end
    repeat (10) @(negedge clk);
    exp_q.push_back('{ok: 1'b1, data: 8'hC3, due: -1});
    last_data = 8'hC3;
    drive_bits(8'hC3, 1'b1, BIT_NS, 0, 9);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ferr_next_drain: %0d strobes missing, required 0", exp_q.size()); exp_q.delete(); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    drive_bits(8'h5A, 1'b1, BIT_NS, 0, 4);
    rx = 1'b1;  // data bit 4 of 0x5A
    #(BIT_NS / 2 + 3);
    reset = 1'b1;
    #1;
    n_cmp++; if (recv_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h, required 00", recv_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    n_cmp++; if (recv_ok !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_strobes: got ok=%b ferr=%b, required 0 0", recv_ok, frame_err); end
    last_data = 8'h00;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    exp_q.push_back('{ok: 1'b1, data: 8'h81, due: -1});
    last_data = 8'h81;
    drive_bits(8'h81, 1'b1, BIT_NS, 0, 9);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL midrst_next_drain: %0d strobes missing, required 0", exp_q.size()); exp_q.delete(); end
    repeat (20) @(negedge clk);
  endtask

  // A 15-clock bit drifts past the bit-6 centre of a 16-clock sampler, so the
  // fast side is exercised at 15.7 clocks per bit (about -2%).
  task automatic test_baud_skew();
    int periods[3];
    periods[0] = 17 * CLK_NS;
    periods[1] = 157;
    periods[2] = 163;
    foreach (periods[k]) begin
      @(negedge clk);
      exp_q.push_back('{ok: 1'b1, data: 8'h96, due: -1});
      last_data = 8'h96;
      drive_bits(8'h96, 1'b1, periods[k], 0, 9);
      for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
      n_cmp++;
      if (exp_q.size() !== 0) begin
        n_fail++;
        $display("FAIL skew_drain_%0dns: %0d strobes missing, required 0", periods[k], exp_q.size());
        exp_q.delete();
      end
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_baud_skew();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
